// File: rtl/lsu_dmem_if_if.sv
// Request/response handshake bundle between the execute stage and the LSU.
interface lsu_dmem_if_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_dmem_if.sv
// Single-outstanding load/store initiator: checks legality, drives one memory
// access cycle, returns data/error over a response handshake, counts events.
module lsu_dmem_if #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic               CLK,
  input  logic               RST,
  lsu_dmem_if_if.slave       bus,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic [2:0]         mem_ctrl,
  output logic               mem_wen,
  input  logic [31:0]        mem_rdata,
  output logic [31:0]        cnt_load,
  output logic [31:0]        cnt_store,
  output logic [31:0]        cnt_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        f3_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        illegal;
  logic [2:0]  size_m1;
  logic [32:0] last_byte;

  // Range check is done in 33 bits so a request near 2^32 cannot wrap to legal.
  always_comb begin
    if (bus.req_we)
      f3_bad = bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11);
    else
      f3_bad = (bus.req_funct3 == 3'b011) | (bus.req_funct3[2:1] == 2'b11);
    size_m1    = 3'd0;
    misaligned = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00: size_m1 = 3'd0;
      2'b01: begin
        size_m1    = 3'd1;
        misaligned = bus.req_addr[0];
      end
      default: begin
        size_m1    = 3'd3;
        misaligned = (bus.req_addr[1:0] != 2'b00);
      end
    endcase
    last_byte    = {1'b0, bus.req_addr} + {30'd0, size_m1};
    out_of_range = last_byte > 33'(MEM_BYTES - 1);
    illegal      = f3_bad | misaligned | out_of_range;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = illegal ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q      <= 1'b0;
      f3_q      <= 3'b010;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_err   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= illegal;
            if (illegal) cnt_err <= cnt_err + 32'd1;
          end
        end
        ACCESS: begin
          rdata_q <= we_q ? '0 : mem_rdata;
          if (we_q) cnt_store <= cnt_store + 32'd1;
          else      cnt_load  <= cnt_load + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory port is idle (word read of address 0) outside the access cycle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_ctrl  = 3'b010;
    mem_wen   = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_ctrl  = f3_q;
      mem_wen   = we_q;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if with a byte-addressed memory model.
module tb_lsu_dmem_if;

  logic        CLK;
  logic        RST;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic [31:0] cnt_load;
  logic [31:0] cnt_store;
  logic [31:0] cnt_err;
  logic        mem_clear;

  lsu_dmem_if_if bus ();

  lsu_dmem_if #(.MEM_BYTES(4096)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ctrl  (mem_ctrl),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata),
    .cnt_load  (cnt_load),
    .cnt_store (cnt_store),
    .cnt_err   (cnt_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: combinational extended read, write on the rising edge.
  logic [7:0]  mem [0:4095];
  logic [11:0] ma;
  always_comb begin
    ma = mem_addr[11:0];
    case (mem_ctrl)
      3'b000:  mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
      3'b100:  mem_rdata = {24'd0, mem[ma]};
      3'b001:  mem_rdata = {{16{mem[ma+12'd1][7]}}, mem[ma+12'd1], mem[ma]};
      3'b101:  mem_rdata = {16'd0, mem[ma+12'd1], mem[ma]};
      default: mem_rdata = {mem[ma+12'd3], mem[ma+12'd2], mem[ma+12'd1], mem[ma]};
    endcase
  end

  always @(posedge CLK) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'd0;
    end else if (mem_wen) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_ctrl[1:0] != 2'b00) mem[ma+12'd1] <= mem_wdata[15:8];
      if (mem_ctrl[1:0] == 2'b10) begin
        mem[ma+12'd2] <= mem_wdata[23:16];
        mem[ma+12'd3] <= mem_wdata[31:24];
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned nl;
    int unsigned ns;
    int unsigned ne;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                              input int unsigned nl, input int unsigned ns, input int unsigned ne);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    v.nl = nl; v.ns = ns; v.ne = ne;
    return v;
  endfunction

  // Issue one request from an IDLE negedge, complete it, end on a negedge in IDLE.
  task automatic run_req(input vec_t v, input string tag);
    int  lat;
    int  wen_n;
    int  touch_n;
    bit  done;
    chk($sformatf("%s req_ready", tag), 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    lat = 1; wen_n = 0; touch_n = 0; done = 0;
    while (!done && lat <= 8) begin
      if (mem_wen) wen_n++;
      if (mem_wen || mem_addr != 32'd0 || mem_wdata != 32'd0 || mem_ctrl != 3'b010) touch_n++;
      if (bus.rsp_valid) done = 1;
      else begin
        @(negedge CLK);
        lat++;
      end
    end
    chk($sformatf("%s latency", tag), 32'(lat), v.err ? 32'd1 : 32'd2);
    chk($sformatf("%s rdata", tag), bus.rsp_rdata, v.rdata);
    chk($sformatf("%s err", tag), 32'(bus.rsp_err), 32'(v.err));
    chk($sformatf("%s wen cycles", tag), 32'(wen_n), (v.we && !v.err) ? 32'd1 : 32'd0);
    if (v.err) chk($sformatf("%s mem untouched", tag), 32'(touch_n), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    chk($sformatf("%s rsp_valid drop", tag), 32'(bus.rsp_valid), 32'd0);
    chk($sformatf("%s cnt_load", tag), cnt_load, 32'(v.nl));
    chk($sformatf("%s cnt_store", tag), cnt_store, 32'(v.ns));
    chk($sformatf("%s cnt_err", tag), cnt_err, 32'(v.ne));
  endtask

  task automatic chk_reset_state(input string tag);
    chk($sformatf("%s req_ready", tag), 32'(bus.req_ready), 32'd1);
    chk($sformatf("%s rsp_valid", tag), 32'(bus.rsp_valid), 32'd0);
    chk($sformatf("%s rsp_rdata", tag), bus.rsp_rdata, 32'd0);
    chk($sformatf("%s rsp_err", tag), 32'(bus.rsp_err), 32'd0);
    chk($sformatf("%s mem_wen", tag), 32'(mem_wen), 32'd0);
    chk($sformatf("%s mem_addr", tag), mem_addr, 32'd0);
    chk($sformatf("%s mem_wdata", tag), mem_wdata, 32'd0);
    chk($sformatf("%s mem_ctrl", tag), 32'(mem_ctrl), 32'd2);
    chk($sformatf("%s cnt_load", tag), cnt_load, 32'd0);
    chk($sformatf("%s cnt_store", tag), cnt_store, 32'd0);
    chk($sformatf("%s cnt_err", tag), cnt_err, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vt [22];
  logic [31:0] b2b_exp [4];
  int          acc;
  int          rsp_n;
  int          wen_seen;

  initial begin
    vt[0]  = mk(1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        0, 0, 1, 0);
    vt[1]  = mk(0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 0, 1, 1, 0);
    vt[2]  = mk(0, 3'b000, 32'h13,       32'h0,        32'hFFFFFFDE, 0, 2, 1, 0);
    vt[3]  = mk(0, 3'b100, 32'h13,       32'h0,        32'h000000DE, 0, 3, 1, 0);
    vt[4]  = mk(0, 3'b001, 32'h12,       32'h0,        32'hFFFFDEAD, 0, 4, 1, 0);
    vt[5]  = mk(0, 3'b101, 32'h10,       32'h0,        32'h0000BEEF, 0, 5, 1, 0);
    vt[6]  = mk(0, 3'b010, 32'h11,       32'h0,        32'h0,        1, 5, 1, 1);
    vt[7]  = mk(1, 3'b001, 32'h21,       32'h1234,     32'h0,        1, 5, 1, 2);
    vt[8]  = mk(1, 3'b010, 32'h1000,     32'h55,       32'h0,        1, 5, 1, 3);
    vt[9]  = mk(0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        1, 5, 1, 4);
    vt[10] = mk(0, 3'b011, 32'h0,        32'h0,        32'h0,        1, 5, 1, 5);
    vt[11] = mk(1, 3'b010, 32'hFFC,      32'h12345678, 32'h0,        0, 5, 2, 5);
    vt[12] = mk(0, 3'b010, 32'hFFC,      32'h0,        32'h12345678, 0, 6, 2, 5);
    vt[13] = mk(1, 3'b000, 32'h20,       32'hFFFFFFA5, 32'h0,        0, 6, 3, 5);
    vt[14] = mk(0, 3'b010, 32'h20,       32'h0,        32'h000000A5, 0, 7, 3, 5);
    vt[15] = mk(0, 3'b000, 32'h20,       32'h0,        32'hFFFFFFA5, 0, 8, 3, 5);
    vt[16] = mk(1, 3'b100, 32'h40,       32'h77,       32'h0,        1, 8, 3, 6);
    vt[17] = mk(0, 3'b110, 32'h40,       32'h0,        32'h0,        1, 8, 3, 7);
    vt[18] = mk(0, 3'b100, 32'hFFF,      32'h0,        32'h00000012, 0, 9, 3, 7);
    vt[19] = mk(0, 3'b001, 32'hFFF,      32'h0,        32'h0,        1, 9, 3, 8);
    vt[20] = mk(0, 3'b000, 32'h1000,     32'h0,        32'h0,        1, 9, 3, 9);
    vt[21] = mk(0, 3'b101, 32'hFFE,      32'h0,        32'h00001234, 0, 10, 3, 9);
    b2b_exp[0] = 32'h000000EF;
    b2b_exp[1] = 32'h000000BE;
    b2b_exp[2] = 32'h000000AD;
    b2b_exp[3] = 32'h000000DE;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    RST = 1'b1; mem_clear = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    mem_clear = 1'b0;
    RST = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 22; i++) run_req(vt[i], $sformatf("vec%0d", i));

    // Back-pressure: response held, a waiting request must not be taken early.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    @(negedge CLK);
    bus.req_addr = 32'hFFC;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp%0d rsp_rdata", c), bus.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp%0d req_ready", c), 32'(bus.req_ready), 32'd0);
      @(negedge CLK);
    end
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    chk("bp post-hs rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp post-hs req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp post-hs mem_wen", 32'(mem_wen), 32'd0);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    chk("bp access mem_addr", mem_addr, 32'hFFC);
    @(negedge CLK);
    chk("bp second rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp second rdata", bus.rsp_rdata, 32'h12345678);
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    chk("bp cnt_load", cnt_load, 32'd12);

    // Reset while a store response is pending.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h40; bus.req_wdata = 32'hCAFEF00D;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    @(negedge CLK);
    chk("rstresp rsp_valid before", 32'(bus.rsp_valid), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_reset_state("rst-in-resp");

    // Reset during the access cycle: the write at that edge still lands.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h30; bus.req_wdata = 32'h11223344;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    chk("rstacc mem_wen in access", 32'(mem_wen), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_reset_state("rst-in-access");
    run_req(mk(0, 3'b010, 32'h30, 32'h0, 32'h11223344, 0, 1, 0, 0), "post-rst");

    // Back-to-back: request and response handshakes held high for 30 cycles.
    acc = 0; rsp_n = 0; wen_seen = 0;
    bus.req_we = 1'b0; bus.req_funct3 = 3'b100; bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.rsp_valid) begin
        chk($sformatf("b2b rsp%0d", rsp_n), bus.rsp_rdata, b2b_exp[rsp_n % 4]);
        rsp_n++;
      end
      if (mem_wen) wen_seen++;
      if (bus.req_ready) begin
        bus.req_addr = 32'h10 + 32'(acc % 4);
        acc++;
      end
      @(negedge CLK);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("b2b responses", 32'(rsp_n), 32'd10);
    chk("b2b accepts", 32'(acc), 32'd10);
    chk("b2b no writes", 32'(wen_seen), 32'd0);
    chk("b2b cnt_load", cnt_load, 32'd11);
    chk("b2b idle", 32'(bus.req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
